// File: rtl/bitpacker_arbiter.sv
// bitpacker_arbiter
//   Shares one bitpacker between N_REQ Huffman-encoder requesters. One
//   requester owns the bitpacker for a whole coded block (until its beat with
//   req_last is accepted); ownership rotates round-robin. Accepted codes are
//   registered onto pack_* one cycle later. The bit position modulo 8 is
//   tracked so that a flush can pad with 1-bits up to the next byte boundary.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/ready/last    : per-requester handshake (N_REQ bits each)
//   req_data   [32*N_REQ]   : right-aligned code of requester i at [32*i +: 32]
//   req_length [6*N_REQ]    : code length of requester i at [6*i +: 6], 0..32
//   grant      [N_REQ]      : one-hot current owner, zero when none
//   flush_req / flush_done  : level request / one-cycle completion pulse
//   pack_valid/data/length  : bitpacker data_in_valid / data_in / input_length
//   busy                    : high whenever the arbiter is not idle
module bitpacker_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [6*N_REQ-1:0]   req_length,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 pack_valid,
  output logic [31:0]          pack_data,
  output logic [5:0]           pack_length,
  output logic                 busy
);

  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, PAD, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [2:0]         bit_pos, bit_pos_nxt;
  logic [N_REQ-1:0]   grant_q, grant_nxt;
  logic               flush_done_q, flush_done_nxt;

  logic               vld_p1, vld_nxt;
  logic [DATA_W-1:0]  data_p1, data_nxt;
  logic [LEN_W-1:0]   len_p1, len_nxt;

  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   sel_len_sat;
  logic               sel_last;
  logic [IDX_W-1:0]   sel_idx;

  logic               found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;

  // Lengths above the 32-bit code width are clamped rather than wrapped.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;
  endfunction

  // Number of padding bits needed to reach the next byte boundary.
  function automatic logic [LEN_W-1:0] pad_len(input logic [2:0] pos);
    return LEN_W'(4'd8 - {1'b0, pos});
  endfunction

  // Padding pattern: pad_len(pos) one-bits, right-aligned.
  function automatic logic [DATA_W-1:0] pad_ones(input logic [2:0] pos);
    return (DATA_W'(1) << pad_len(pos)) - DATA_W'(1);
  endfunction

  // Steer the owning requester's beat; grant_q is one-hot or zero.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_len   = '0;
    sel_last  = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[DATA_W*i +: DATA_W];
        sel_len   = req_length[LEN_W*i +: LEN_W];
        sel_last  = req_last[i];
        sel_idx   = IDX_W'(i);
      end
    end
    sel_len_sat = sat_len(sel_len);
  end

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    rr_ptr_nxt     = rr_ptr;
    bit_pos_nxt    = bit_pos;
    flush_done_nxt = 1'b0;
    vld_nxt        = 1'b0;
    data_nxt       = data_p1;
    len_nxt        = len_p1;

    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = PAD;
        end else if (found) begin
          state_nxt = GRANT;
          grant_nxt = N_REQ'(1) << pick_idx;
        end
      end

      GRANT: begin
        if (sel_valid) begin
          // Zero-length beats are consumed but never reach the bitpacker.
          if (sel_len_sat != '0) begin
            vld_nxt     = 1'b1;
            data_nxt    = sel_data;
            len_nxt     = sel_len_sat;
            bit_pos_nxt = bit_pos + sel_len_sat[2:0];
          end
          if (sel_last) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
          end
        end
      end

      PAD: begin
        if (bit_pos != 3'd0) begin
          vld_nxt  = 1'b1;
          data_nxt = pad_ones(bit_pos);
          len_nxt  = pad_len(bit_pos);
        end
        bit_pos_nxt    = 3'd0;
        flush_done_nxt = 1'b1;
        state_nxt      = DONE;
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- stage p1: registered control state and forwarded beat ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      bit_pos      <= 3'd0;
      grant_q      <= '0;
      flush_done_q <= 1'b0;
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      len_p1       <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      bit_pos      <= bit_pos_nxt;
      grant_q      <= grant_nxt;
      flush_done_q <= flush_done_nxt;
      vld_p1       <= vld_nxt;
      data_p1      <= data_nxt;
      len_p1       <= len_nxt;
    end
  end

  // req_ready mirrors the registered grant: only the owner may transfer.
  assign grant       = grant_q;
  assign req_ready   = grant_q;
  assign flush_done  = flush_done_q;
  assign pack_valid  = vld_p1;
  assign pack_data   = data_p1;
  assign pack_length = len_p1;
  assign busy        = (state != IDLE);

endmodule
